// File: rtl/ntt_bf_addr_gen_pkg.sv
// ntt_bf_addr_gen_pkg: shared NTT constants, FSM state type and butterfly index helper.
package ntt_bf_addr_gen_pkg;

    localparam int MAX_LOG_N = 12;

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    function automatic int n_of(input int log_n);
        return 1 << log_n;
    endfunction

    function automatic int half_n_of(input int log_n);
        return 1 << (log_n - 1);
    endfunction

    // Insert a zero at bit position l of m: lower address of butterfly m at half-span 2^l.
    function automatic logic [MAX_LOG_N-1:0] bf_index(input logic [MAX_LOG_N-1:0] m, input logic [3:0] l);
        logic [MAX_LOG_N-1:0] mask;
        mask = (MAX_LOG_N'(1) << l) - MAX_LOG_N'(1);
        return ((m >> l) << (l + 4'd1)) | (m & mask);
    endfunction

endpackage

// File: rtl/ntt_bf_addr_gen_tw_exp_calc.sv
// ntt_tw_exp_calc: combinational twiddle exponent from butterfly m, stage s and direction.
module ntt_tw_exp_calc
    import ntt_bf_addr_gen_pkg::*;
#(
    parameter int LOG_N = 3
) (
    input  logic [LOG_N-2:0]         m,
    input  logic [$clog2(LOG_N)-1:0] s,
    input  logic                     inv,
    output logic [LOG_N-2:0]         tw_exp
);

    localparam int SW = $clog2(LOG_N);
    localparam int MW = LOG_N - 1;

    logic [SW-1:0] l;
    logic [SW-1:0] sh;
    logic [MW-1:0] mask;

    assign l      = inv ? s : SW'(LOG_N - 1) - s;
    assign sh     = inv ? SW'(LOG_N - 1) - s : s;
    // At l = LOG_N-1 the shift overflows to zero, so the mask wraps to all ones as intended.
    assign mask   = (MW'(1) << l) - MW'(1);
    assign tw_exp = (m & mask) << sh;

endmodule

// File: rtl/ntt_bf_addr_gen.sv
// ntt_bf_addr_gen: sequential butterfly index/twiddle-exponent generator for an in-place NTT/INTT.
module ntt_bf_addr_gen
    import ntt_bf_addr_gen_pkg::*;
#(
    parameter int LOG_N     = 3,
    parameter int STAGE_GAP = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     inv,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LOG_N-1:0]         index1,
    output logic [LOG_N-1:0]         index2,
    output logic [LOG_N-2:0]         tw_exp,
    output logic [$clog2(LOG_N)-1:0] stage,
    output logic                     last_in_stage,
    output logic                     done
);

    localparam int SW     = $clog2(LOG_N);
    localparam int MW     = LOG_N - 1;
    localparam int HALF_N = half_n_of(LOG_N);
    localparam logic [3:0] GAP_LOAD = 4'(STAGE_GAP == 0 ? 0 : STAGE_GAP - 1);

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] s;
    logic [MW-1:0] m;
    logic [3:0]    gap_cnt;
    logic          inv_q;
    logic          accept;
    logic          last_m;
    logic          last_s;
    logic [SW-1:0] l;
    logic [LOG_N-1:0] idx1;
    logic [MW-1:0] tw;

    assign out_valid     = state == RUN;
    assign busy          = state == RUN || state == GAP;
    assign done          = state == DONE;
    assign accept        = out_valid && out_ready;
    assign last_m        = m == MW'(HALF_N - 1);
    assign last_s        = s == SW'(LOG_N - 1);
    assign l             = inv_q ? s : SW'(LOG_N - 1) - s;
    assign idx1          = LOG_N'(bf_index(MAX_LOG_N'(m), 4'(l)));
    // Index and exponent buses read zero whenever no pair is being offered.
    assign index1        = out_valid ? idx1 : '0;
    assign index2        = out_valid ? idx1 + (LOG_N'(1) << l) : '0;
    assign tw_exp        = out_valid ? tw : '0;
    assign stage         = s;
    assign last_in_stage = out_valid && last_m;

    ntt_tw_exp_calc #(.LOG_N(LOG_N)) u_tw (
        .m      (m),
        .s      (s),
        .inv    (inv_q),
        .tw_exp (tw)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     if (accept && last_m) state_nx = last_s ? DONE : (STAGE_GAP > 0 ? GAP : RUN);
            GAP:     state_nx = gap_cnt == 4'd0 ? RUN : GAP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s       <= '0;
            m       <= '0;
            gap_cnt <= '0;
            inv_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                inv_q <= inv;
                s     <= '0;
                m     <= '0;
            end
            if (accept) begin
                m <= m + MW'(1);
                if (last_m) begin
                    s       <= last_s ? '0 : s + SW'(1);
                    gap_cnt <= GAP_LOAD;
                end
            end
            if (state == GAP && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_ntt_bf_addr_gen.sv
// tb_ntt_bf_addr_gen: directed checks of forward/inverse order, backpressure, stage gaps, reset and start filtering.
module tb_ntt_bf_addr_gen;

    logic clk = 1'b0;
    logic rst;
    logic inv;
    always #5 clk = ~clk;

    logic start0, rdy0, busy0, v0, last0, done0;
    logic [2:0] i1_0, i2_0;
    logic [1:0] tw0, st0;

    logic start1, rdy1, busy1, v1, last1, done1;
    logic [3:0] i1_1, i2_1;
    logic [2:0] tw1;
    logic [1:0] st1;

    logic start2, rdy2, busy2, v2, last2, done2;
    logic [2:0] i1_2, i2_2;
    logic [1:0] tw2, st2;

    ntt_bf_addr_gen #(.LOG_N(3), .STAGE_GAP(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .inv(inv), .busy(busy0), .out_valid(v0),
        .out_ready(rdy0), .index1(i1_0), .index2(i2_0), .tw_exp(tw0), .stage(st0),
        .last_in_stage(last0), .done(done0)
    );

    ntt_bf_addr_gen #(.LOG_N(4), .STAGE_GAP(0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .inv(inv), .busy(busy1), .out_valid(v1),
        .out_ready(rdy1), .index1(i1_1), .index2(i2_1), .tw_exp(tw1), .stage(st1),
        .last_in_stage(last1), .done(done1)
    );

    ntt_bf_addr_gen #(.LOG_N(3), .STAGE_GAP(3)) u2 (
        .clk(clk), .rst(rst), .start(start2), .inv(inv), .busy(busy2), .out_valid(v2),
        .out_ready(rdy2), .index1(i1_2), .index2(i2_2), .tw_exp(tw2), .stage(st2),
        .last_in_stage(last2), .done(done2)
    );

    int passed = 0;
    int total  = 0;

    int f1[12]  = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int f2[12]  = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int ftw[12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
    int r1[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int r2[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int rtw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    int e1[$], e2[$], etw[$], est[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_idle0(input string tag);
        chk({tag, "_valid"}, 32'(v0), 0);
        chk({tag, "_busy"}, 32'(busy0), 0);
        chk({tag, "_done"}, 32'(done0), 0);
        chk({tag, "_i1"}, 32'(i1_0), 0);
        chk({tag, "_i2"}, 32'(i2_0), 0);
        chk({tag, "_tw"}, 32'(tw0), 0);
        chk({tag, "_stage"}, 32'(st0), 0);
        chk({tag, "_last"}, 32'(last0), 0);
    endtask

    initial begin
        int acc, lasts, cyc;
        logic got_done, stalled, rdy;
        logic [3:0] p1, p2;
        logic [2:0] ptw;
        rst = 1'b1; inv = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        rdy0 = 1'b1; rdy1 = 1'b0; rdy2 = 1'b1;
        tick();
        tick();
        chk_idle0("reset");
        rst = 1'b0;
        tick();

        // forward, with a start pulse mid-transform that must be ignored
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("fwd_valid", 32'(v0), 1);
            chk("fwd_busy", 32'(busy0), 1);
            chk("fwd_i1", 32'(i1_0), 32'(f1[k]));
            chk("fwd_i2", 32'(i2_0), 32'(f2[k]));
            chk("fwd_tw", 32'(tw0), 32'(ftw[k]));
            chk("fwd_stage", 32'(st0), 32'(k / 4));
            chk("fwd_last", 32'(last0), 32'(k % 4 == 3));
            start0 = (k == 5);
            tick();
        end
        start0 = 1'b0;
        chk("fwd_done", 32'(done0), 1);
        chk("fwd_done_busy", 32'(busy0), 0);
        chk("fwd_done_valid", 32'(v0), 0);

        // start in DONE is ignored, start in the next IDLE cycle is taken
        start0 = 1'b1;
        tick();
        chk("done_start_valid", 32'(v0), 0);
        chk("done_start_busy", 32'(busy0), 0);
        chk("done_start_done", 32'(done0), 0);
        tick();
        start0 = 1'b0;
        chk("restart_valid", 32'(v0), 1);
        chk("restart_i1", 32'(i1_0), 0);
        chk("restart_i2", 32'(i2_0), 4);

        // reset in the middle of stage 1
        repeat (5) tick();
        chk("mid_stage", 32'(st0), 1);
        chk("mid_i1", 32'(i1_0), 1);
        chk("mid_i2", 32'(i2_0), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle0("midrst");
        tick();
        chk("midrst_stay_valid", 32'(v0), 0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("fresh_valid", 32'(v0), 1);
        chk("fresh_i1", 32'(i1_0), 0);
        chk("fresh_i2", 32'(i2_0), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // inverse; inv is dropped right after start to show it is latched
        inv = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        inv = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("inv_valid", 32'(v0), 1);
            chk("inv_i1", 32'(i1_0), 32'(r1[k]));
            chk("inv_i2", 32'(i2_0), 32'(r2[k]));
            chk("inv_tw", 32'(tw0), 32'(rtw[k]));
            chk("inv_stage", 32'(st0), 32'(k / 4));
            chk("inv_last", 32'(last0), 32'(k % 4 == 3));
            tick();
        end
        chk("inv_done", 32'(done0), 1);

        // LOG_N=4 forward reference order, enumerated group by group
        for (int s = 0; s < 4; s++) begin
            int t;
            t = 8 >> s;
            for (int j = 0; j < 16; j += 2 * t)
                for (int i = j; i < j + t; i++) begin
                    e1.push_back(i);
                    e2.push_back(i + t);
                    etw.push_back((i - j) << s);
                    est.push_back(s);
                end
        end
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        acc = 0; lasts = 0; cyc = 0;
        got_done = 1'b0; stalled = 1'b0;
        p1 = '0; p2 = '0; ptw = '0;
        while (!got_done && cyc < 2000) begin
            if (stalled) begin
                chk("stall_valid", 32'(v1), 1);
                chk("stall_i1", 32'(i1_1), 32'(p1));
                chk("stall_i2", 32'(i2_1), 32'(p2));
                chk("stall_tw", 32'(tw1), 32'(ptw));
            end
            got_done = done1;
            rdy = 1'($urandom_range(0, 1));
            rdy1 = rdy;
            stalled = v1 && !rdy;
            p1 = i1_1; p2 = i2_1; ptw = tw1;
            if (v1 && rdy) begin
                if (acc < 32) begin
                    chk("bp_i1", 32'(i1_1), 32'(e1[acc]));
                    chk("bp_i2", 32'(i2_1), 32'(e2[acc]));
                    chk("bp_tw", 32'(tw1), 32'(etw[acc]));
                    chk("bp_stage", 32'(st1), 32'(est[acc]));
                end
                acc++;
                if (last1) lasts++;
            end
            tick();
            cyc++;
        end
        rdy1 = 1'b0;
        chk("bp_done_seen", 32'(got_done), 1);
        chk("bp_accepts", 32'(acc), 32);
        chk("bp_last_count", 32'(lasts), 4);

        // STAGE_GAP=3: valid in cycles 1-4, 8-11, 15-18, done in 19
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            chk("gap_valid", 32'(v2), 32'((c <= 4) || (c >= 8 && c <= 11) || (c >= 15 && c <= 18)));
            chk("gap_busy", 32'(busy2), 32'(c <= 18));
            chk("gap_done", 32'(done2), 32'(c == 19));
            if (c == 8) chk("gap_s1_i2", 32'(i2_2), 2);
            if (c == 15) chk("gap_s2_i2", 32'(i2_2), 1);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
